// File: rtl/clkdiv_bank_if.sv
// Half-period write port of clkdiv_bank: master issues single-cycle writes, slave answers with wr_ack.
// Writes are never stalled; a rejected write simply produces no wr_ack.
interface clkdiv_bank_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    localparam int WCH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             wr_en;
    logic [WCH_W-1:0] wr_ch;
    logic [CNT_W-1:0] wr_data;
    logic             wr_ack;

    modport master (output wr_en, output wr_ch, output wr_data, input  wr_ack);
    modport slave  (input  wr_en, input  wr_ch, input  wr_data, output wr_ack);
endinterface

// File: rtl/clkdiv_bank.sv
// Bank of NCH programmable clock dividers (square or single-cycle pulse) with shadowed half-period registers.
// All outputs registered, one cycle after the deciding edge; writes always accepted or dropped, never stalled.
module clkdiv_bank #(
    parameter int NCH       = 4,
    parameter int CNT_W     = 16,
    parameter int RESET_DIV = 888
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] en,
    input  logic [NCH-1:0] mode,
    clkdiv_bank_if.slave   wr,
    output logic [NCH-1:0] clkdiv,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pending
);
    localparam int               WCH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WCH_W:0]   NCH_L   = (WCH_W + 1)'(NCH);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(RESET_DIV);

    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][CNT_W-1:0] nact_q, nact_d;
    logic [NCH-1:0][CNT_W-1:0] nshd_q, nshd_d;
    logic [NCH-1:0]            pend_q, pend_d;
    logic [NCH-1:0]            div_q, div_d;
    logic [NCH-1:0]            tick_q, tick_d;
    logic [NCH-1:0]            pmode_q, pmode_d;
    logic [NCH-1:0]            tc, apply, wr_hit;
    logic                      wr_ok;
    logic                      ack_q;

    assign wr_ok = wr.wr_en && ({1'b0, wr.wr_ch} < NCH_L) && (wr.wr_data != '0);

    always_comb begin
        tc     = '0;
        apply  = '0;
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            tc[i]     = en[i] && (cnt_q[i] == nact_q[i] - CNT_W'(1));
            // A disabled channel has no half-period in flight, so the shadow can land at once.
            apply[i]  = pend_q[i] && (tc[i] || !en[i]);
            wr_hit[i] = wr_ok && (wr.wr_ch == WCH_W'(i));
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        nact_d  = nact_q;
        nshd_d  = nshd_q;
        pend_d  = pend_q;
        div_d   = div_q;
        tick_d  = tick_q;
        pmode_d = pmode_q;
        for (int i = 0; i < NCH; i++) begin
            if (apply[i]) begin
                nact_d[i] = nshd_q[i];
            end
            if (wr_hit[i]) begin
                nshd_d[i] = wr.wr_data;
                pend_d[i] = 1'b1;
            end else if (apply[i]) begin
                pend_d[i] = 1'b0;
            end

            if (!en[i]) begin
                cnt_d[i]   = '0;
                div_d[i]   = 1'b0;
                tick_d[i]  = 1'b0;
                pmode_d[i] = 1'b0;
            end else if (tc[i]) begin
                cnt_d[i]   = '0;
                tick_d[i]  = 1'b1;
                div_d[i]   = mode[i] | ~div_q[i];
                pmode_d[i] = mode[i];
            end else begin
                cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                tick_d[i] = 1'b0;
                // Only a level produced by a pulse-mode terminal count is short-lived.
                if (pmode_q[i]) begin
                    div_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            nact_q  <= {NCH{DIV_RST}};
            nshd_q  <= {NCH{DIV_RST}};
            pend_q  <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            pmode_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            nact_q  <= nact_d;
            nshd_q  <= nshd_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            pmode_q <= pmode_d;
            ack_q   <= wr_ok;
        end
    end

    assign clkdiv    = div_q;
    assign tick      = tick_q;
    assign pending   = pend_q;
    assign wr.wr_ack = ack_q;
endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed scenarios for clkdiv_bank; expected output events are queued in cycle order and matched by a monitor.
module tb_clkdiv_bank;
    // Five channels so that wr_ch = NCH is representable and can be shown to be rejected.
    localparam int NCH       = 5;
    localparam int CNT_W     = 16;
    localparam int RESET_DIV = 888;
    localparam int WCH_W     = (NCH > 1) ? $clog2(NCH) : 1;

    localparam int K_ACK  = 0;
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;
    localparam int K_TICK = 3;
    localparam int K_PSET = 4;
    localparam int K_PCLR = 5;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  ch;
        logic [2:0]  kind;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NCH-1:0] en = '0;
    logic [NCH-1:0] mode = '0;
    logic [NCH-1:0] clkdiv, tick, pending;

    clkdiv_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) wr_if ();

    clkdiv_bank #(.NCH(NCH), .CNT_W(CNT_W), .RESET_DIV(RESET_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .wr     (wr_if),
        .clkdiv (clkdiv),
        .tick   (tick),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk  = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    logic [NCH-1:0] prev_div  = '0;
    logic [NCH-1:0] prev_pend = '0;

    function automatic string kname(input int k);
        case (k)
            K_ACK:   return "wr_ack";
            K_RISE:  return "clkdiv_rise";
            K_FALL:  return "clkdiv_fall";
            K_TICK:  return "tick";
            K_PSET:  return "pending_set";
            default: return "pending_clr";
        endcase
    endfunction

    function automatic ev_t mk(input int unsigned c, input int ch, input int kind);
        ev_t e;
        e.cyc  = c;
        e.ch   = 4'(ch);
        e.kind = 3'(kind);
        return e;
    endfunction

    function automatic string edesc(input ev_t e);
        return $sformatf("%s ch%0d @%0d", kname(int'(e.kind)), e.ch, e.cyc);
    endfunction

    // Sorted insertion keeps the queue in (cycle, channel, kind) order, matching the monitor's scan.
    function automatic void expect_ev(input int unsigned c, input int ch, input int kind);
        ev_t e;
        int  i;
        e = mk(c, ch, kind);
        i = 0;
        while (i < exp_q.size() && exp_q[i] <= e) i++;
        exp_q.insert(i, e);
    endfunction

    function automatic void expect_square(input int ch, input int unsigned first, input int unsigned half,
                                          input int n, input bit lvl0);
        bit l;
        l = lvl0;
        for (int j = 0; j < n; j++) begin
            l = ~l;
            expect_ev(first + j * half, ch, l ? K_RISE : K_FALL);
            expect_ev(first + j * half, ch, K_TICK);
        end
    endfunction

    always @(negedge clk) begin
        obs_q.delete();
        if (wr_if.wr_ack) obs_q.push_back(mk(cyc, 0, K_ACK));
        for (int i = 0; i < NCH; i++) begin
            if (clkdiv[i] && !prev_div[i])   obs_q.push_back(mk(cyc, i, K_RISE));
            if (!clkdiv[i] && prev_div[i])   obs_q.push_back(mk(cyc, i, K_FALL));
            if (tick[i])                     obs_q.push_back(mk(cyc, i, K_TICK));
            if (pending[i] && !prev_pend[i]) obs_q.push_back(mk(cyc, i, K_PSET));
            if (!pending[i] && prev_pend[i]) obs_q.push_back(mk(cyc, i, K_PCLR));
        end
        prev_div  = clkdiv;
        prev_pend = pending;

        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL sb_missing: required %s, observed nothing", edesc(exp_q[0]));
            void'(exp_q.pop_front());
        end
        foreach (obs_q[k]) begin
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0] < obs_q[k]) begin
                n_chk++; n_fail++;
                $display("FAIL sb_missing: required %s, observed nothing", edesc(exp_q[0]));
                void'(exp_q.pop_front());
            end
            n_chk++;
            if (exp_q.size() > 0 && exp_q[0] == obs_q[k]) begin
                void'(exp_q.pop_front());
            end else begin
                n_fail++;
                $display("FAIL sb_unexpected: observed %s, required next %s", edesc(obs_q[k]),
                         (exp_q.size() > 0) ? edesc(exp_q[0]) : "none");
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            n_chk++; n_fail++;
            $display("FAIL sb_missing: required %s, observed nothing", edesc(exp_q[0]));
            void'(exp_q.pop_front());
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic goto_cyc(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input int ch, input int data);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_ch   = WCH_W'(ch);
        wr_if.wr_data = CNT_W'(data);
        @(posedge clk);
        #1;
        wr_if.wr_en   = 1'b0;
        wr_if.wr_ch   = '0;
        wr_if.wr_data = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d events still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k, k2, k3;
        wr_if.wr_en   = 1'b0;
        wr_if.wr_ch   = '0;
        wr_if.wr_data = '0;

        // Reset asserted before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clkdiv",  int'(clkdiv),       0);
        chk("rst_tick",    int'(tick),         0);
        chk("rst_pending", int'(pending),      0);
        chk("rst_wr_ack",  int'(wr_if.wr_ack), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default divider on ch0, with illegal writes interleaved
        k = cyc;
        en[0] = 1'b1;
        expect_square(0, k + 888, 888, 3, 1'b0);
        goto_cyc(k + 100);
        do_write(0, 0);
        do_write(NCH, 100);
        do_write(7, 100);
        goto_cyc(k + 2700);
        en[0] = 1'b0;
        expect_ev(k + 2701, 0, K_FALL);
        goto_cyc(k + 2710);

        // Live retune of ch1 from 888 to 264
        k = cyc;
        en[1] = 1'b1;
        expect_square(1, k + 888, 888, 2, 1'b0);
        goto_cyc(k + 1188);
        do_write(1, 264);
        expect_ev(k + 1189, 0, K_ACK);
        expect_ev(k + 1189, 1, K_PSET);
        expect_ev(k + 1776, 1, K_PCLR);
        expect_square(1, k + 2040, 264, 3, 1'b0);
        goto_cyc(k + 2600);
        en[1] = 1'b0;
        expect_ev(k + 2601, 1, K_FALL);
        goto_cyc(k + 2610);

        // Pulse mode on ch2 with N=5, programmed while idle
        k = cyc;
        do_write(2, 5);
        expect_ev(k + 1, 0, K_ACK);
        expect_ev(k + 1, 2, K_PSET);
        expect_ev(k + 2, 2, K_PCLR);
        goto_cyc(k + 5);
        k2 = cyc;
        mode[2] = 1'b1;
        en[2]   = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            expect_ev(k2 + 5 * j, 2, K_RISE);
            expect_ev(k2 + 5 * j, 2, K_TICK);
            expect_ev(k2 + 5 * j + 1, 2, K_FALL);
        end
        goto_cyc(k2 + 32);
        en[2]   = 1'b0;
        mode[2] = 1'b0;
        goto_cyc(k2 + 40);

        // Write landing in the terminal-count cycle on ch3
        k = cyc;
        do_write(3, 20);
        expect_ev(k + 1, 0, K_ACK);
        expect_ev(k + 1, 3, K_PSET);
        expect_ev(k + 2, 3, K_PCLR);
        goto_cyc(k + 5);
        k2 = cyc;
        en[3] = 1'b1;
        expect_square(3, k2 + 20, 20, 2, 1'b0);
        goto_cyc(k2 + 25);
        do_write(3, 499);
        expect_ev(k2 + 26, 0, K_ACK);
        expect_ev(k2 + 26, 3, K_PSET);
        goto_cyc(k2 + 39);
        do_write(3, 353);
        expect_ev(k2 + 40, 0, K_ACK);
        expect_square(3, k2 + 539, 499, 1, 1'b0);
        expect_ev(k2 + 539, 3, K_PCLR);
        expect_square(3, k2 + 892, 353, 2, 1'b1);
        goto_cyc(k2 + 1250);
        en[3] = 1'b0;
        expect_ev(k2 + 1251, 3, K_FALL);
        goto_cyc(k2 + 1260);

        // N=1 on ch4: square toggles every clock, pulse stays high
        k = cyc;
        do_write(4, 1);
        expect_ev(k + 1, 0, K_ACK);
        expect_ev(k + 1, 4, K_PSET);
        expect_ev(k + 2, 4, K_PCLR);
        goto_cyc(k + 3);
        k2 = cyc;
        en[4] = 1'b1;
        expect_square(4, k2 + 1, 1, 6, 1'b0);
        goto_cyc(k2 + 6);
        en[4] = 1'b0;
        goto_cyc(k2 + 8);
        k3 = cyc;
        mode[4] = 1'b1;
        en[4]   = 1'b1;
        expect_ev(k3 + 1, 4, K_RISE);
        for (int j = 1; j <= 5; j++) expect_ev(k3 + j, 4, K_TICK);
        goto_cyc(k3 + 5);
        en[4]   = 1'b0;
        mode[4] = 1'b0;
        expect_ev(k3 + 6, 4, K_FALL);
        goto_cyc(k3 + 10);

        // Asynchronous reset while ch1 is high with a write pending
        k = cyc;
        en[1] = 1'b1;
        expect_square(1, k + 264, 264, 1, 1'b0);
        goto_cyc(k + 298);
        do_write(1, 77);
        expect_ev(k + 299, 0, K_ACK);
        expect_ev(k + 299, 1, K_PSET);
        goto_cyc(k + 300);
        chk("pre_rst_clkdiv1", int'(clkdiv[1]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_clkdiv",  int'(clkdiv),       0);
        chk("arst_tick",    int'(tick),         0);
        chk("arst_pending", int'(pending),      0);
        chk("arst_wr_ack",  int'(wr_if.wr_ack), 0);
        expect_ev(k + 300, 1, K_FALL);
        expect_ev(k + 300, 1, K_PCLR);
        #1 rst_n = 1'b1;
        expect_square(1, k + 1188, 888, 1, 1'b0);
        goto_cyc(k + 1200);
        en[1] = 1'b0;
        expect_ev(k + 1201, 1, K_FALL);
        goto_cyc(k + 1210);

        chk("sb_leftover", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: width of counters and half-period registers.
REQ-003 SHALL have parameter RESET_DIV, default 888: half-period loaded into every channel at reset (1..2^CNT_W-1).
REQ-004 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port en  input  NCH: per-channel run enable.
REQ-007 SHALL have port mode  input  NCH: per-channel output mode; 0 = square (50% duty), 1 = pulse (one-cycle high).
REQ-008 SHALL have port wr_en  input  1: half-period write strobe.
REQ-009 SHALL have port wr_ch  input  max(1,$clog2(NCH)): target channel of a write.
REQ-010 SHALL have port wr_data  input  CNT_W: new half-period value N.
REQ-011 SHALL have port wr_ack  output  1: one-cycle strobe confirming an accepted write.
REQ-012 SHALL have port clkdiv  output  NCH: divided outputs, registered.
REQ-013 SHALL have port tick  output  NCH: one-cycle strobe per channel at each terminal count, registered.
REQ-014 SHALL have port pending  output  NCH: a shadow half-period is waiting to be applied.

Function
REQ-015 SHALL keep per channel: active half-period N_act, shadow N_shd, counter cnt (CNT_W bits) and pending flag.
REQ-016 SHALL, with en[i]=1 and cnt=N_act-1 (terminal count), set cnt to 0 and assert tick[i] on the next cycle; otherwise increment cnt.
REQ-017 SHALL, in square mode, toggle clkdiv[i] at each terminal count, giving period 2*N_act clocks.
REQ-018 SHALL, in pulse mode, drive clkdiv[i] equal to tick[i], giving period N_act clocks with one clock high.
REQ-019 SHALL sample mode[i] every cycle; square-to-pulse or pulse-to-square switching keeps the current clkdiv level until the next terminal count.
REQ-020 SHALL accept a write when wr_en=1, wr_ch<NCH and wr_data!=0: N_shd[wr_ch]<=wr_data, pending[wr_ch]<=1, wr_ack=1 on the next cycle.
REQ-021 SHALL ignore writes with wr_ch>=NCH or wr_data=0: no state change, wr_ack stays 0.
REQ-022 SHALL apply the shadow at a terminal count with pending=1: N_act<=N_shd, pending<=0, new value governs the following half-period; switching is glitch-free.
REQ-023 SHALL, when a write and a terminal count on the same channel coincide, apply the previous N_shd at that boundary, store the new value and keep pending=1 for the next boundary.
REQ-024 SHALL, with en[i]=0, hold cnt=0, clkdiv[i]=0, tick[i]=0, and apply any pending shadow immediately (pending clears the next cycle).
REQ-025 SHALL, on en[i] rising, start counting from 0 so the first terminal count occurs N_act cycles later.
REQ-026 SHALL support N=1: square toggles every clock (clk/2); pulse holds clkdiv high continuously while enabled.
REQ-027 SHALL keep channels fully independent; a write to one channel never disturbs another.

Reset
REQ-028 SHALL, while rst_n=0 and without a clock, force cnt=0, N_act=N_shd=RESET_DIV, pending=0, clkdiv=0, tick=0, wr_ack=0.
REQ-029 SHALL resume on the first rising clk edge after rst_n deasserts; a reset mid-operation discards all counts and pending writes.

Verification
REQ-030 SHALL cover reset default: en=0001, mode=0 after reset -> clkdiv[0] rises 888 clocks after en, then period 1776; other channels stay 0.
REQ-031 SHALL cover live retune: write ch1 wr_data=264 mid half-period while running at 888 -> wr_ack one cycle later, pending[1]=1 until next toggle, then half-periods of 264, no short or long pulse.
REQ-032 SHALL cover pulse mode: ch2 N=5, mode=1 -> tick[2]=clkdiv[2] high exactly 1 cycle in every 5.
REQ-033 SHALL cover illegal writes: wr_data=0 on ch0, then wr_ch=NCH -> wr_ack=0, no pending, periods unchanged.
REQ-034 SHALL cover coincidence: pending value 499 on ch3, write 353 in the terminal-count cycle -> next half-period 499, then 353, pending cleared after second boundary.
REQ-035 SHALL cover async reset: rst_n pulsed low between clock edges with clkdiv=1 -> all outputs 0 immediately, restart from RESET_DIV.
